filter_mode_ctrl: RTL

FILTER_MODE_CTRL -- requirements
Module: filter_mode_ctrl

---
 rtl/filter_pkg.sv | 29 ++
 rtl/key_debounce.sv | 65 ++++++
 rtl/filter_mode_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_pkg
//  Description : Shared definitions for the filter mode controller: the LCD
//                redraw handshake state type and the key index map used to
//                address the four push buttons.
//  Revision    : 1.0  initial release
// ============================================================================
package filter_pkg;

  // LCD redraw handshake states.
  //   IDLE : no redraw outstanding
  //   REQ  : lcd_req asserted, waiting for lcd_ack
  //   GAP  : one-cycle lcd_req low gap before re-requesting a newer mode
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } hs_state_t;

  // Bit positions of the buttons inside the key bus.
  localparam int KEY_NEXT = 0;
  localparam int KEY_PREV = 1;
  localparam int KEY_HOME = 2;
  localparam int KEY_LOCK = 3;
  localparam int NUM_KEYS = 4;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchroniser + debouncer + press detector for one active-low
//                push button. The raw input is brought into the clock domain
//                with two flops; the debounced level only follows the
//                synchronised level once it has differed from it for
//                DEBOUNCE_CYCLES consecutive cycles. A one-cycle press pulse
//                is produced on every accepted 1->0 transition, so a held key
//                yields exactly one press.
//  Ports       : clk      in   system clock
//                reset    in   asynchronous active-high reset
//                i_key_n  in   raw active-low button level (asynchronous)
//                o_press  out  one-cycle pulse per debounced press
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Released state everywhere so reset can never look like a press.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        // Any bounce back to the accepted level restarts the stability run.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Synchronised level differed for DEBOUNCE_CYCLES cycles in a row.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/filter_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : filter_mode_ctrl
//  Description : Push-button driven filter mode selector with a lock toggle
//                and a request/acknowledge handshake towards an LCD driver.
//                Next/prev step the mode with wrap-around, home returns to
//                mode 0, lock inhibits mode changes. Every mode change asks
//                the LCD to redraw; changes arriving while a redraw is still
//                outstanding are coalesced into one follow-up redraw of the
//                latest mode.
//  Ports       : clk          in   system clock (50 MHz)
//                reset        in   asynchronous active-high reset
//                key[3:0]     in   raw active-low buttons: next/prev/home/lock
//                filter_type  out  current mode (registered)
//                locked       out  high while mode changes are inhibited
//                lcd_req      out  redraw request to the LCD driver
//                lcd_mode     out  mode to draw, valid while lcd_req is high
//                lcd_ack      in   one-cycle redraw acceptance pulse
//  Revision    : 1.0  initial release
// ============================================================================
module filter_mode_ctrl
  import filter_pkg::*;
#(
  parameter  int NUM_MODES       = 4,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int MW              = $clog2(NUM_MODES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    key,
  output logic [MW-1:0] filter_type,
  output logic          locked,
  output logic          lcd_req,
  output logic [MW-1:0] lcd_mode,
  input  logic          lcd_ack
);

  localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);

  // --------------------------------------------------------------------------
  // Key conditioning: one synchroniser/debouncer per button
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] w_press;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_key_n (key[gi]),
      .o_press (w_press[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Mode and lock registers
  // --------------------------------------------------------------------------
  logic [MW-1:0] r_filter_type;
  logic          r_locked;
  logic          r_change;
  logic [MW-1:0] w_mode_nxt;
  logic          w_change;

  // Priority home > next > prev; the lock state sampled here is the one in
  // force before any lock press of this same cycle takes effect.
  always_comb begin
    w_mode_nxt = r_filter_type;
    if (!r_locked) begin
      if (w_press[KEY_HOME]) begin
        w_mode_nxt = '0;
      end else if (w_press[KEY_NEXT]) begin
        w_mode_nxt = (r_filter_type == LAST_MODE) ? '0 : r_filter_type + MW'(1);
      end else if (w_press[KEY_PREV]) begin
        w_mode_nxt = (r_filter_type == '0) ? LAST_MODE : r_filter_type - MW'(1);
      end
    end
  end

  // Only a different value counts as a change (home at mode 0 is silent).
  assign w_change = (w_mode_nxt != r_filter_type);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filter_type <= '0;
      r_locked      <= 1'b0;
      r_change      <= 1'b0;
    end else begin
      r_filter_type <= w_mode_nxt;
      r_change      <= w_change;
      if (w_press[KEY_LOCK]) begin
        r_locked <= ~r_locked;
      end
    end
  end

  // --------------------------------------------------------------------------
  // LCD redraw handshake
  // r_change is high in the first cycle filter_type holds its new value, so
  // loading lcd_mode from r_filter_type then captures the new mode and raises
  // lcd_req one cycle after the change.
  // --------------------------------------------------------------------------
  hs_state_t     r_state;
  hs_state_t     w_state;
  logic          r_pending;
  logic          w_pending;
  logic          w_load;
  logic [MW-1:0] r_lcd_mode;

  always_comb begin
    w_state   = r_state;
    w_pending = r_pending;
    w_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_change) begin
          w_state = REQ;
          w_load  = 1'b1;
        end
      end
      REQ: begin
        if (lcd_ack) begin
          // A change landing on the ack cycle still needs its own redraw.
          if (r_pending || r_change) begin
            w_state   = GAP;
            w_pending = 1'b1;
          end else begin
            w_state = IDLE;
          end
        end else if (r_change) begin
          w_pending = 1'b1;
        end
      end
      GAP: begin
        // The reload captures the latest mode, which also covers any change
        // that became visible during this gap cycle.
        w_state   = REQ;
        w_pending = 1'b0;
        w_load    = 1'b1;
      end
      default: begin
        w_state   = IDLE;
        w_pending = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_lcd_mode <= '0;
    end else begin
      r_state   <= w_state;
      r_pending <= w_pending;
      if (w_load) begin
        r_lcd_mode <= r_filter_type;
      end
    end
  end

  assign filter_type = r_filter_type;
  assign locked      = r_locked;
  assign lcd_req     = (r_state == REQ);
  assign lcd_mode    = r_lcd_mode;

endmodule
`default_nettype wire
